// File: rtl/vga_pkg.sv
// ============================================================================
// Module      : vga_pkg
// Description : Shared timing constants for the 640x480@60 VGA raster and
//               the counter width/type used by the timing generator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vga_pkg;

    // Count width; axis totals above 1024 are not supported.
    localparam int COUNT_W = 10;

    typedef logic [COUNT_W-1:0] count_t;

    // Default 640x480@60 timing (pixels / lines)
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    function automatic int axis_total(input int active, input int fp,
                                      input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    localparam int DEF_H_TOTAL = axis_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
    localparam int DEF_V_TOTAL = axis_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

endpackage

`default_nettype wire

// File: rtl/vga_axis_counter.sv
// ============================================================================
// Module      : vga_axis_counter
// Description : Wrap counter for one raster axis. Counts 0..TOTAL-1 when
//               enabled, flags the terminal count, and decodes the active
//               and sync ranges of the *next* count so the parent can
//               register them in step with the count itself.
// Revision    : 1.0 - initial release
//
// Ports
//   clk        in   clock
//   rst_n      in   asynchronous active-low reset (count -> TOTAL-1)
//   en         in   advance the count this clock
//   count      out  current count (registered)
//   carry      out  current count is TOTAL-1 (next advance wraps)
//   active_nxt out  next count is in [0, ACTIVE-1]
//   sync_nxt   out  next count is in [SYNC_START, SYNC_START+SYNC_LEN-1]
// ============================================================================
`default_nettype none

module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int TOTAL      = 800,
    parameter int ACTIVE     = 640,
    parameter int SYNC_START = 656,
    parameter int SYNC_LEN   = 96
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   en,
    output count_t count,
    output logic   carry,
    output logic   active_nxt,
    output logic   sync_nxt
);

    localparam count_t LAST    = count_t'(TOTAL - 1);
    localparam count_t ACT_END = count_t'(ACTIVE);
    localparam count_t SYNC_LO = count_t'(SYNC_START);
    localparam count_t SYNC_HI = count_t'(SYNC_START + SYNC_LEN - 1);

    count_t count_q;
    count_t count_d;

    always_comb begin
        count_d = count_q;
        if (en) begin
            count_d = (count_q == LAST) ? '0 : count_q + count_t'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= LAST;
        end else begin
            count_q <= count_d;
        end
    end

    assign count      = count_q;
    assign carry      = (count_q == LAST);
    assign active_nxt = (count_d < ACT_END);
    assign sync_nxt   = (count_d >= SYNC_LO) && (count_d <= SYNC_HI);

endmodule

`default_nettype wire

// File: rtl/vga_timing.sv
// ============================================================================
// Module      : vga_timing
// Description : VGA raster timing generator (default 640x480@60). Produces
//               position counters, active-low connector syncs, an active-high
//               v_sync level and a one-clock frame_start pulse. Every decode
//               output is registered from the next-count value, so it always
//               describes the position shown on h_count/v_count.
// Revision    : 1.0 - initial release
//
// Build option
//   VGA_TIMING_CLKDIV_EN  defined  : pixel_tick on alternate clocks (clk/2),
//                                    first tick on the 2nd clock after reset
//                         undefined: position advances on every clock
//
// Ports
//   clk            in   system clock
//   rst_n          in   asynchronous active-low reset
//   pixel_tick     out  high on each clock in which the position advanced
//   h_count        out  pixel column 0..H_TOTAL-1
//   v_count        out  line 0..V_TOTAL-1
//   display_enable out  inside the visible area
//   v_sync         out  active-high vertical sync level
//   hs_n           out  horizontal sync, active-low
//   vs_n           out  vertical sync, active-low
//   frame_start    out  one-clock pulse on entering (0,0)
// ============================================================================
`default_nettype none

module vga_timing
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               pixel_tick,
    output logic [COUNT_W-1:0] h_count,
    output logic [COUNT_W-1:0] v_count,
    output logic               display_enable,
    output logic               v_sync,
    output logic               hs_n,
    output logic               vs_n,
    output logic               frame_start
);

    localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    logic advance;

`ifdef VGA_TIMING_CLKDIV_EN
    // Divide-by-2 toggle: low on the first clock after reset, so the first
    // advance happens on the second clock.
    logic div_q;
    logic div_d;

    always_comb begin
        div_d = ~div_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= 1'b0;
        end else begin
            div_q <= div_d;
        end
    end

    assign advance = div_q;
`else
    // Flops are held in reset, so a constant enable means the first clock
    // after release is already a tick.
    assign advance = 1'b1;
`endif

    count_t h_cnt;
    count_t v_cnt;
    logic   h_carry;
    logic   v_carry;
    logic   h_active_nxt;
    logic   v_active_nxt;
    logic   h_sync_nxt;
    logic   v_sync_nxt;
    logic   v_en;

    // Vertical axis steps only on the tick that wraps the horizontal axis.
    assign v_en = h_carry & advance;

    vga_axis_counter #(
        .TOTAL      (H_TOTAL),
        .ACTIVE     (H_ACTIVE),
        .SYNC_START (H_ACTIVE + H_FP),
        .SYNC_LEN   (H_SYNC)
    ) u_h_axis (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (advance),
        .count      (h_cnt),
        .carry      (h_carry),
        .active_nxt (h_active_nxt),
        .sync_nxt   (h_sync_nxt)
    );

    vga_axis_counter #(
        .TOTAL      (V_TOTAL),
        .ACTIVE     (V_ACTIVE),
        .SYNC_START (V_ACTIVE + V_FP),
        .SYNC_LEN   (V_SYNC)
    ) u_v_axis (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (v_en),
        .count      (v_cnt),
        .carry      (v_carry),
        .active_nxt (v_active_nxt),
        .sync_nxt   (v_sync_nxt)
    );

    logic pixel_tick_q,     pixel_tick_d;
    logic display_enable_q, display_enable_d;
    logic v_sync_q,         v_sync_d;
    logic hs_n_q,           hs_n_d;
    logic vs_n_q,           vs_n_d;
    logic frame_start_q,    frame_start_d;

    always_comb begin
        pixel_tick_d     = advance;
        display_enable_d = h_active_nxt & v_active_nxt;
        v_sync_d         = v_sync_nxt;
        hs_n_d           = ~h_sync_nxt;
        vs_n_d           = ~v_sync_nxt;
        // Both axes at their terminal count and advancing: next is (0,0).
        frame_start_d    = advance & h_carry & v_carry;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel_tick_q     <= 1'b0;
            display_enable_q <= 1'b0;
            v_sync_q         <= 1'b0;
            hs_n_q           <= 1'b1;
            vs_n_q           <= 1'b1;
            frame_start_q    <= 1'b0;
        end else begin
            pixel_tick_q     <= pixel_tick_d;
            display_enable_q <= display_enable_d;
            v_sync_q         <= v_sync_d;
            hs_n_q           <= hs_n_d;
            vs_n_q           <= vs_n_d;
            frame_start_q    <= frame_start_d;
        end
    end

    assign pixel_tick     = pixel_tick_q;
    assign h_count        = h_cnt;
    assign v_count        = v_cnt;
    assign display_enable = display_enable_q;
    assign v_sync         = v_sync_q;
    assign hs_n           = hs_n_q;
    assign vs_n           = vs_n_q;
    assign frame_start    = frame_start_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_timing.sv
// ============================================================================
// Module      : tb_vga_timing
// Description : Self-checking bench for vga_timing. A full-size 640x480
//               instance checks reset, line timing and horizontal sync; a
//               reduced-geometry instance makes whole frames (vertical sync,
//               frame wrap, frame period) reachable in a short run. Expected
//               values come from a raster-index model: position p counts
//               ticks since reset modulo the frame size, h = p % H_TOTAL,
//               v = p / H_TOTAL.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_timing;

    localparam int HA = 640, HFP = 16, HS = 96, HBP = 48;
    localparam int VA = 480, VFP = 10, VS = 2,  VBP = 33;
    localparam int FB = (HA + HFP + HS + HBP) * (VA + VFP + VS + VBP);

    localparam int SHA = 16, SHFP = 4, SHS = 6, SHBP = 5;
    localparam int SVA = 12, SVFP = 3, SVS = 2, SVBP = 4;
    localparam int FSM = (SHA + SHFP + SHS + SHBP) * (SVA + SVFP + SVS + SVBP);

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       b_tick, b_de, b_vsy, b_hsn, b_vsn, b_fs;
    logic [9:0] b_h, b_v;
    logic       s_tick, s_de, s_vsy, s_hsn, s_vsn, s_fs;
    logic [9:0] s_h, s_v;

    always #5 clk = ~clk;

    vga_timing u_big (
        .clk            (clk),
        .rst_n          (rst_n),
        .pixel_tick     (b_tick),
        .h_count        (b_h),
        .v_count        (b_v),
        .display_enable (b_de),
        .v_sync         (b_vsy),
        .hs_n           (b_hsn),
        .vs_n           (b_vsn),
        .frame_start    (b_fs)
    );

    vga_timing #(
        .H_ACTIVE (SHA), .H_FP (SHFP), .H_SYNC (SHS), .H_BP (SHBP),
        .V_ACTIVE (SVA), .V_FP (SVFP), .V_SYNC (SVS), .V_BP (SVBP)
    ) u_small (
        .clk            (clk),
        .rst_n          (rst_n),
        .pixel_tick     (s_tick),
        .h_count        (s_h),
        .v_count        (s_v),
        .display_enable (s_de),
        .v_sync         (s_vsy),
        .hs_n           (s_hsn),
        .vs_n           (s_vsn),
        .frame_start    (s_fs)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state
    int clocks_since = 0;   // clocks since reset release
    int p_big   = -1;       // raster index, -1 = reset position
    int p_small = -1;
    bit adv_exp = 1'b0;
    int ticks   = 0;
    int last_fs = -1;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            if (bad <= 40)
                $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_axis(input string pre, input int p,
                              input int ha, input int hfp, input int hs, input int hbp,
                              input int va, input int vfp, input int vs, input int vbp,
                              input int tick, input int h, input int v, input int de,
                              input int vsy, input int hsn, input int vsn, input int fs);
        int ht, vt, eh, ev, ede, evs, ehs, etk, efs;
        ht = ha + hfp + hs + hbp;
        vt = va + vfp + vs + vbp;
        if (p < 0) begin
            eh = ht - 1; ev = vt - 1; ede = 0; evs = 0; ehs = 1; etk = 0; efs = 0;
        end else begin
            eh  = p % ht;
            ev  = p / ht;
            ede = int'(eh < ha && ev < va);
            evs = int'(ev >= va + vfp && ev < va + vfp + vs);
            ehs = int'(!(eh >= ha + hfp && eh < ha + hfp + hs));
            etk = int'(adv_exp);
            efs = int'(adv_exp && p == 0);
        end
        check({pre, ".tick"}, tick, etk);
        check({pre, ".h"},    h,    eh);
        check({pre, ".v"},    v,    ev);
        check({pre, ".de"},   de,   ede);
        check({pre, ".vsync"}, vsy, evs);
        check({pre, ".hs_n"}, hsn,  ehs);
        check({pre, ".vs_n"}, vsn,  1 - evs);
        check({pre, ".fs"},   fs,   efs);
    endtask

    task automatic check_all();
        check_axis("big", p_big, HA, HFP, HS, HBP, VA, VFP, VS, VBP,
                   b_tick, b_h, b_v, b_de, b_vsy, b_hsn, b_vsn, b_fs);
        check_axis("small", p_small, SHA, SHFP, SHS, SHBP, SVA, SVFP, SVS, SVBP,
                   s_tick, s_h, s_v, s_de, s_vsy, s_hsn, s_vsn, s_fs);
    endtask

    task automatic model_reset();
        clocks_since = 0;
        adv_exp      = 1'b0;
        p_big        = -1;
        p_small      = -1;
        last_fs      = -1;
    endtask

    // One clock: update the model at the rising edge, compare at the falling edge.
    task automatic step();
        @(posedge clk);
        if (rst_n) begin
            clocks_since++;
`ifdef VGA_TIMING_CLKDIV_EN
            adv_exp = (clocks_since % 2 == 0);
`else
            adv_exp = 1'b1;
`endif
            if (adv_exp) begin
                p_big   = (p_big + 1) % FB;
                p_small = (p_small + 1) % FSM;
                ticks++;
            end
        end else begin
            model_reset();
        end
        @(negedge clk);
        check_all();
        if (s_fs) begin
            if (last_fs >= 0)
                check("small.frame_period", ticks - last_fs, FSM);
            last_fs = ticks;
        end
    endtask

    // Assert reset between edges and check it takes effect without a clock.
    task automatic async_reset(input int hold);
        #($urandom_range(1, 4));
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        repeat (hold) step();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        repeat (3300) step();
        for (int i = 0; i < 5; i++) begin
            repeat ($urandom_range(100, 2500)) step();
            async_reset(int'($urandom_range(1, 3)));
        end
        repeat (3000) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/vga_timing.md
# vga_timing

Generates 640x480@60 VGA raster timing: horizontal/vertical position counters, active-low sync pins for the connector, and the active-high `v_sync` level and `frame_start` pulse consumed by the game-control stage. It sits directly upstream of game control and the pixel renderer. Its `v_sync` is the signal game control uses to re-arm its once-per-frame update pulse.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal front porch / sync / back porch in pixels
- V_ACTIVE, 480, visible lines per frame
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical front porch / sync / back porch in lines
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- pixel_tick  out  1  high on every clock in which the position advances
- h_count  out  10  current pixel column, 0..H_TOTAL-1
- v_count  out  10  current line, 0..V_TOTAL-1
- display_enable  out  1  high when h_count < H_ACTIVE and v_count < V_ACTIVE
- v_sync  out  1  active-high; high while v_count is in the vertical sync interval
- hs_n  out  1  connector horizontal sync, active-low
- vs_n  out  1  connector vertical sync, active-low (inverse of v_sync)
- frame_start  out  1  one-clock pulse when position enters (0,0)

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- On each pixel_tick: h_count increments; at H_TOTAL-1 it wraps to 0 and v_count increments; v_count wraps from V_TOTAL-1 to 0 on that same tick.
- Horizontal sync region: h_count in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], which is [656,751]. hs_n is low there.
- Vertical sync region: v_count in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], which is [490,491]. v_sync is high there, for the whole line regardless of h_count. vs_n = !v_sync.
- frame_start is high when (h_count,v_count) = (0,0) on the clock following the tick that entered it. It is never held longer than one clock.
- Counters are saturating-free. Widths are fixed at 10 bits, and parameter sets with H_TOTAL or V_TOTAL > 1024 are unsupported.

## Timing
- All outputs are registered and decoded from the next-count value, so every decode output describes the position shown in h_count/v_count on the same clock. No skew between counters and syncs.
- Reset values: h_count=H_TOTAL-1 (799), v_count=V_TOTAL-1 (524), display_enable=0, v_sync=0, hs_n=1, vs_n=1, frame_start=0, pixel_tick=0.
- The first pixel_tick after reset deassertion moves to (0,0) with frame_start=1 and display_enable=1.
- Reset asserted mid-frame returns all outputs to reset values immediately (asynchronous), with no partial frame continuation.
- Frame period: H_TOTAL*V_TOTAL pixel ticks (420000).
- The v_sync high interval is 2*H_TOTAL ticks.

## Configuration
- VGA_TIMING_CLKDIV_EN defined: an internal toggle divides clock by 2. pixel_tick is high on alternate clocks, starting on the second clock after reset release. Counters and decodes change only on those clocks, and frame_start stays one clock wide.
- Undefined: pixel_tick is constant 1 after reset release (first clock after release is a tick), and position advances every clock.

## Structure
- Shared package `vga_pkg`: default timing constants for 640x480@60, derived H_TOTAL/V_TOTAL, and count width (10).
- One sub-module, `vga_axis_counter`: a parameterised wrap counter with enable, carry-out at terminal count, and active/sync range decode. It is instantiated once for the horizontal axis and once for the vertical axis, with the vertical enable driven by the horizontal carry ANDed with pixel_tick.

## Test plan
- Reset held, then released, macro undefined -> after 1 clock h=0,v=0, frame_start=1, display_enable=1; next clock frame_start=0, h=1.
- Run one line -> hs_n low exactly for h=656..751 (96 ticks); display_enable low from h=640; h wraps 799->0 and v increments 0->1 on the same clock.
- Run to line 490 -> v_sync=1/vs_n=0 for all 1600 ticks of lines 490-491, then deasserted at (0,492).
- Run two full frames -> frame_start pulses exactly 420000 ticks apart; v wraps 524->0 together with h 799->0.
- Assert reset at (300,200) -> outputs return to reset values asynchronously, within the same clock period; after release, restart at (0,0) with frame_start.
- VGA_TIMING_CLKDIV_EN defined -> pixel_tick alternates; one line takes 1600 clocks; frame_start stays 1 clock wide.
